// File: rtl/reg_dump_streamer.sv
// rtl/reg_dump_streamer.sv - register bank dump streamer with XOR checksum trailer
module reg_dump_streamer #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_reg_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic              o_stall_req,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NB - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LATCH, S_SEND, S_CHK, S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_chk;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_stall;
  logic              r_busy;
  logic              r_done;

  logic              w_xfer;
  logic [DATA_W-1:0] w_shift_next;

  assign w_xfer       = r_tx_valid & i_tx_ready;
  assign w_shift_next = r_shift << 8;

  // Dump sequencer: all outputs are registered; abort outranks any handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_chk      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_stall    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (r_state != S_IDLE && i_abort) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_chk      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_stall    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_state <= S_SETTLE;
            r_busy  <= 1'b1;
            r_stall <= 1'b1;
          end
        end
        // one quiet cycle lets a falling-edge bank write land before sampling
        S_SETTLE: begin
          r_chk   <= '0;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_shift    <= i_reg_data;
          r_cnt      <= '0;
          r_tx_data  <= i_reg_data[DATA_W-1 -: 8];
          r_tx_valid <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_chk   <= r_chk ^ r_tx_data;
            r_shift <= w_shift_next;
            if (r_cnt == LAST_BYTE) begin
              if (r_addr == LAST_ADDR) begin
                // checksum byte must include the byte being accepted now
                r_tx_data <= r_chk ^ r_tx_data;
                r_state   <= S_CHK;
              end else begin
                r_addr     <= r_addr + 1'b1;
                r_tx_valid <= 1'b0;
                r_tx_data  <= '0;
                r_state    <= S_LATCH;
              end
            end else begin
              r_cnt     <= r_cnt + 1'b1;
              r_tx_data <= w_shift_next[DATA_W-1 -: 8];
            end
          end
        end
        S_CHK: begin
          if (w_xfer) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_stall <= 1'b0;
          r_addr  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_reg_addr  = r_addr;
  assign o_stall_req = r_stall;
  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// tb/tb_reg_dump_streamer.sv - self-checking bench for reg_dump_streamer
module tb_reg_dump_streamer;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NB       = DATA_W / 8;
  localparam int FULL_BYTES = NUM_REGS * NB + 1;
  localparam int BUDGET   = 3000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              tx_ready = 1'b0;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_data;
  logic              stall_req;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [NUM_REGS];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign reg_data = mem[reg_addr];

  reg_dump_streamer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .o_reg_addr (reg_addr),
    .i_reg_data (reg_data),
    .o_stall_req(stall_req),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_busy     (busy),
    .o_done     (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // register bank contents for each named pattern
  task automatic fill(input int pattern);
    for (int i = 0; i < NUM_REGS; i++) begin
      case (pattern)
        0: mem[i] = 32'h01010101 * i;
        1: mem[i] = (i == 0) ? 32'hDEADBEEF : 32'h0;
        2: mem[i] = (i == 0) ? 32'h12345678 : 32'h0;
        4: mem[i] = 32'hFFFFFFFF;
        default: mem[i] = $urandom;
      endcase
    end
  endtask

  // reference stream: every register MSB byte first, then XOR of all bytes
  logic [7:0] exp_q[$];
  task automatic build_expected();
    logic [7:0] x;
    logic [7:0] b;
    logic [DATA_W-1:0] w;
    x = 8'h00;
    exp_q.delete();
    for (int r = 0; r < NUM_REGS; r++) begin
      w = mem[r];
      for (int k = NB - 1; k >= 0; k--) begin
        b = 8'((w >> (8 * k)) & 32'hFF);
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
    exp_q.push_back(x);
  endtask

  logic [7:0] got_q[$];
  int done_cnt, done_cyc, first_valid_cyc, idle_cyc, stall_bad, hold_bad, addr_bad;

  // drive one dump; cycle 1 is the cycle right after the start edge
  task automatic run_dump(input int mode, input int abort_cyc, input int restart_cyc);
    logic pv, pr;
    logic [7:0] pd;
    int ea;
    got_q.delete();
    done_cnt = 0; done_cyc = 0; first_valid_cyc = 0; idle_cyc = 0;
    stall_bad = 0; hold_bad = 0; addr_bad = 0;
    pv = 1'b0; pr = 1'b1; pd = 8'h00;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= BUDGET; cyc++) begin
      if (cyc > 1) @(negedge clk);
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (cyc % 3 == 1);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      start = (cyc == restart_cyc);
      abort = (cyc == abort_cyc);
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
      if (pv && !pr && (!tx_valid || tx_data !== pd)) hold_bad++;
      if (tx_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (!stall_req) stall_bad++;
      if (tx_valid && tx_ready && !abort) begin
        ea = got_q.size() / NB;
        if (ea > NUM_REGS - 1) ea = NUM_REGS - 1;
        if (int'(reg_addr) != ea) addr_bad++;
        got_q.push_back(tx_data);
      end
      pv = tx_valid; pr = tx_ready; pd = tx_data;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int bad;
    bad = 0;
    chk({tag, " byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    chk({tag, " stream_mismatches"}, bad, 0);
  endtask

  typedef struct {
    int pattern;
    int mode;
    int exp_cksum;     // -1: take from reference model
    int exp_done_cyc;  // 0: not fixed for this ready pattern
    int restart_cyc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vec_t v;
    logic [7:0] last;
    int idle_bad;

    vecs.push_back('{0, 0, 8'h00, 163, 0});
    vecs.push_back('{1, 1, 8'h22, 0,   0});
    vecs.push_back('{0, 0, 8'h00, 163, 50});
    vecs.push_back('{2, 2, 8'h08, 0,   0});
    vecs.push_back('{4, 0, 8'h00, 163, 0});
    for (int i = 0; i < 4; i++) vecs.push_back('{3, (i == 0) ? 0 : 2, -1, (i == 0) ? 163 : 0, 0});

    fill(0);

    // reset and idle behaviour
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, stall_req, tx_valid, done, tx_data, 3'b0, reg_addr}, 64'h0);
    rst_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid || busy || stall_req || done || reg_addr != '0) idle_bad++;
    end
    chk("idle_violations", idle_bad, 0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_in_idle busy", busy, 1'b0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_and_abort busy", busy, 1'b0);
    @(negedge clk);
    chk("start_and_abort stall", stall_req, 1'b0);

    // table-driven full dumps
    foreach (vecs[n]) begin
      v = vecs[n];
      fill(v.pattern);
      build_expected();
      run_dump(v.mode, 0, v.restart_cyc);
      check_stream($sformatf("vec%0d", n));
      last = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 8'hxx;
      chk($sformatf("vec%0d checksum", n), last,
          (v.exp_cksum < 0) ? exp_q[exp_q.size() - 1] : 8'(v.exp_cksum));
      chk($sformatf("vec%0d done_count", n), done_cnt, 1);
      chk($sformatf("vec%0d finished", n), idle_cyc != 0, 1'b1);
      chk($sformatf("vec%0d idle_after_done", n), idle_cyc, done_cyc + 1);
      chk($sformatf("vec%0d first_valid", n), first_valid_cyc, 3);
      chk($sformatf("vec%0d stall_low", n), stall_bad, 0);
      chk($sformatf("vec%0d hold_bad", n), hold_bad, 0);
      chk($sformatf("vec%0d addr_bad", n), addr_bad, 0);
      if (v.exp_done_cyc != 0) chk($sformatf("vec%0d done_cyc", n), done_cyc, v.exp_done_cyc);
      chk($sformatf("vec%0d total_bytes", n), got_q.size(), FULL_BYTES);
    end

    // abort while the third byte of reg 5 is on the bus
    fill(3);
    run_dump(0, 30, 0);
    chk("abort idle_cyc", idle_cyc, 31);
    chk("abort outputs", {busy, stall_req, tx_valid, done, 3'b0, reg_addr}, 64'h0);
    chk("abort done_count", done_cnt, 0);
    chk("abort bytes_sent", got_q.size(), 5 * NB + 2);
    repeat (3) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort late_done", done_cnt, 0);
    fill(0);
    build_expected();
    run_dump(0, 0, 0);
    check_stream("redump");
    chk("redump done_cyc", done_cyc, 163);
    chk("redump checksum", (got_q.size() > 0) ? got_q[got_q.size() - 1] : 8'hxx, 8'h00);

    // asynchronous reset mid-SEND
    tx_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_reset tx_valid", tx_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset outputs", {busy, stall_req, tx_valid, done, tx_data, 3'b0, reg_addr}, 64'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset busy", {busy, stall_req, tx_valid, done}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_dump_streamer.md
Name: reg_dump_streamer

Overview:
- Debug-side reader for the register bank's asynchronous inspection port (address out, 32-bit data in).
- On a start request it holds the pipeline stalled, walks registers 0..NUM_REGS-1 and streams each value MSB-byte-first over a byte valid/ready interface.
- After the last register it appends one XOR checksum byte.
- Sits between the register bank debug port and the UART transmitter in the debug unit.

Parameters:
- NUM_REGS, 32, number of registers dumped (addresses 0..NUM_REGS-1).
- ADDR_W, 5, width of the register address; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32, register width; must be a multiple of 8.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  dump request; sampled only in IDLE.
- abort  input  1  cancels a dump in progress.
- reg_addr  output  ADDR_W  address driven to the register bank asynchronous read port.
- reg_data  input  DATA_W  asynchronous read data for reg_addr.
- stall_req  output  1  high while the dump owns the register bank; the pipeline must freeze.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a dump completes normally.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. reg_addr=0, tx_data=0. tx_valid=0, stall_req=0, busy=0, done=0. Shift register, byte counter and checksum cleared. Asynchronous reset in mid-dump drops all outputs immediately; no done pulse.
- States: IDLE, SETTLE, LATCH, SEND, CHK, DONE.
- IDLE:
  - Outputs low, reg_addr=0.
  - start=1 at edge k -> SETTLE; busy=1 and stall_req=1 from after edge k.
- SETTLE:
  - One cycle, so that any register-bank write still in flight (written on the falling edge) lands.
  - Checksum cleared -> LATCH.
- LATCH:
  - shift <= reg_data (read at the current reg_addr); byte_cnt <= 0 -> SEND.
- SEND:
  - tx_valid=1, tx_data=shift[DATA_W-1 -: 8].
  - On tx_valid&tx_ready: checksum ^= tx_data; shift <<= 8; byte_cnt++.
  - Last byte accepted (byte_cnt==DATA_W/8-1):
    - reg_addr==NUM_REGS-1 -> CHK;
    - otherwise reg_addr++ -> LATCH.
  - tx_ready=0 holds tx_data and tx_valid stable.
- CHK:
  - tx_valid=1, tx_data=accumulated checksum (XOR of all data bytes).
  - On handshake -> DONE.
- DONE:
  - done=1 for exactly this cycle; busy and stall_req still 1.
  - Next edge -> IDLE, where busy, stall_req and done read 0.
- Timing:
  - First tx_valid is asserted 3 cycles after the start edge: SETTLE, LATCH, then SEND.
  - With tx_ready held at 1, each register costs 1+DATA_W/8 cycles.
  - Total from start edge to done, defaults: 1 + 32*5 + 1 = 162 cycles; done high in cycle 163.
- abort=1 in any non-IDLE state: next edge -> IDLE, all outputs low, no done, no checksum. An abort in SEND or CHK takes priority over a concurrent handshake; that byte counts as not sent. abort in IDLE is ignored.
- start while busy is ignored. start and abort high together in IDLE: stay IDLE.
- Register contents are read only in LATCH. reg_addr is stable during every SEND of its register.
- reg_addr never exceeds NUM_REGS-1 and never wraps within a dump.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release, start=0 for 10 cycles -> tx_valid=0, busy=0, stall_req=0, reg_addr=0 throughout.
- Full dump with tx_ready=1: register i holds 0x01010101*i -> 129 bytes in order:
  - 00 00 00 00, 01 01 01 01, ... 1F 1F 1F 1F;
  - then checksum 0x00 (XOR of all the i values taken 4 times);
  - done pulses exactly once, 162 cycles after the start edge;
  - stall_req is high from the start edge until the edge after done.
- Backpressure: reg 0=0xDEADBEEF, others 0, tx_ready toggling 1,0,0,1... -> first 4 bytes DE AD BE EF; tx_data stable while tx_ready=0; checksum = DE^AD^BE^EF = 0x22.
- Abort mid-dump: abort=1 while sending byte 2 of reg 5 -> one cycle later busy=0, stall_req=0, tx_valid=0, no done. A new start then re-dumps from reg 0 with a fresh checksum.
- Start while busy and asynchronous reset: a second start pulse mid-dump has no effect (still 129 bytes). reset=0 asserted asynchronously between clock edges during SEND -> outputs go to 0 before the next rising edge.
